// File: rtl/gauss_pkg.sv
// Shared types and constants for the 1x5 gaussian filter and its frame sequencer.
// No logic; the filter and its controller both import this package.
package gauss_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_WAIT_SOF,
        ST_STREAM,
        ST_DRAIN
    } state_t;

    localparam int DEF_WIDTH      = 640;
    localparam int DEF_HEIGHT     = 512;
    localparam int DEF_DATA_WIDTH = 8;

    // 1-4-6-4-1 kernel, normalised by a right shift of COEFF_SHIFT.
    localparam int COEFF0      = 1;
    localparam int COEFF1      = 4;
    localparam int COEFF2      = 6;
    localparam int COEFF3      = 4;
    localparam int COEFF4      = 1;
    localparam int COEFF_SHIFT = 4;

    function automatic int cnt_w(input int limit);
        return (limit > 1) ? $clog2(limit) : 1;
    endfunction

endpackage

// File: rtl/gauss_line_counter.sv
// Column/row position of the current pixel with wrap; flags last column and last pixel of frame.
// Flags are combinational from the registered position; advance takes effect on the next edge.
module gauss_line_counter
    import gauss_pkg::*;
#(
    parameter int  WIDTH  = DEF_WIDTH,
    parameter int  HEIGHT = DEF_HEIGHT,
    localparam int COL_W  = cnt_w(WIDTH),
    localparam int ROW_W  = cnt_w(HEIGHT)
) (
    input  logic             clk,
    input  logic             rst_ni,
    input  logic             i_clr,
    input  logic             i_adv,
    output logic [COL_W-1:0] o_col,
    output logic [ROW_W-1:0] o_row,
    output logic             o_last_col,
    output logic             o_eof
);

    localparam logic [COL_W-1:0] COL_MAX = COL_W'(WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(HEIGHT - 1);

    logic [COL_W-1:0] r_col;
    logic [ROW_W-1:0] r_row;
    logic             w_last_col;
    logic             w_last_row;

    assign w_last_col = (r_col == COL_MAX);
    assign w_last_row = (r_row == ROW_MAX);

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_clr) begin
            r_col <= '0;
            r_row <= '0;
        end else if (i_adv) begin
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign o_col      = r_col;
    assign o_row      = r_row;
    assign o_last_col = w_last_col;
    assign o_eof      = w_last_col && w_last_row;

endmodule

// File: rtl/gauss_frame_ctrl.sv
// Frame sequencer ahead of the 1x5 gaussian filter: arms frames, aligns to SOF, regenerates tlast, tracks completion.
// Pixel path is one registered cycle; s_axis_tready is tied high, so beats outside a frame are dropped.
module gauss_frame_ctrl
    import gauss_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int HEIGHT        = DEF_HEIGHT,
    parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int OUT_LINES     = 510,
    parameter int FLUSH_CYCLES  = 4,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic                  clk,
    input  logic                  rst_ni,
    input  logic                  cfg_start,
    input  logic                  cfg_continuous,
    input  logic                  cfg_abort,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tuser,
    output logic                  s_axis_tready,
    output logic                  f_rst_o,
    output logic [DATA_WIDTH-1:0] f_axis_tdata,
    output logic                  f_axis_tvalid,
    output logic                  f_axis_tlast,
    input  logic                  f_out_tvalid,
    input  logic                  f_out_tlast,
    output logic                  busy_o,
    output logic                  frame_done_o,
    output logic                  err_sof_o,
    output logic                  err_timeout_o,
    output logic [15:0]           frame_cnt_o
);

    localparam int COL_W   = cnt_w(WIDTH);
    localparam int ROW_W   = cnt_w(HEIGHT);
    localparam int FLUSH_W = cnt_w(FLUSH_CYCLES);
    localparam int LINE_W  = cnt_w(OUT_LINES + 1);
    localparam int TO_W    = cnt_w(DRAIN_TIMEOUT);

    localparam logic [FLUSH_W-1:0] FLUSH_LAST = FLUSH_W'(FLUSH_CYCLES - 1);
    localparam logic [LINE_W-1:0]  LINES_MAX  = LINE_W'(OUT_LINES);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(DRAIN_TIMEOUT - 1);

    logic [1:0]            r_rst_sync;
    logic                  w_rst_n;
    state_t                r_state;
    logic                  r_f_rst;
    logic                  r_f_tvalid;
    logic                  r_f_tlast;
    logic [DATA_WIDTH-1:0] r_f_tdata;
    logic                  r_done;
    logic                  r_err_sof;
    logic                  r_err_to;
    logic [15:0]           r_frame_cnt;
    logic [FLUSH_W-1:0]    r_flush;
    logic [LINE_W-1:0]     r_lines;
    logic [TO_W-1:0]       r_to;

    logic [COL_W-1:0]      w_col;
    logic [ROW_W-1:0]      w_row;
    logic                  w_last_col;
    logic                  w_eof;
    logic                  w_abort;
    logic                  w_bad_sof;
    logic                  w_fwd;
    logic                  w_clr;
    logic                  w_out_last;
    logic [LINE_W-1:0]     w_lines_nxt;

    // Reset asserts asynchronously but releases on the clock so all state leaves reset together.
    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rst_sync <= '0;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b1};
        end
    end

    assign w_rst_n = r_rst_sync[1];

    gauss_line_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_line_counter (
        .clk        (clk),
        .rst_ni     (w_rst_n),
        .i_clr      (w_clr),
        .i_adv      (w_fwd),
        .o_col      (w_col),
        .o_row      (w_row),
        .o_last_col (w_last_col),
        .o_eof      (w_eof)
    );

    always_comb begin
        w_abort     = cfg_abort && (r_state != ST_IDLE);
        w_bad_sof   = (r_state == ST_STREAM) && s_axis_tvalid && s_axis_tuser
                      && !((w_col == '0) && (w_row == '0));
        w_fwd       = !w_abort && s_axis_tvalid
                      && (((r_state == ST_WAIT_SOF) && s_axis_tuser)
                          || ((r_state == ST_STREAM) && !w_bad_sof));
        w_clr       = w_abort || w_bad_sof || (r_state == ST_IDLE) || (r_state == ST_FLUSH);
        w_out_last  = f_out_tvalid && f_out_tlast;
        w_lines_nxt = (r_lines == LINES_MAX) ? r_lines : r_lines + 1'b1;
    end

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state     <= ST_IDLE;
            r_f_rst     <= 1'b1;
            r_f_tvalid  <= 1'b0;
            r_f_tlast   <= 1'b0;
            r_f_tdata   <= '0;
            r_done      <= 1'b0;
            r_err_sof   <= 1'b0;
            r_err_to    <= 1'b0;
            r_frame_cnt <= '0;
            r_flush     <= '0;
            r_lines     <= '0;
            r_to        <= '0;
        end else begin
            r_f_tvalid <= 1'b0;
            r_f_tlast  <= 1'b0;
            r_done     <= 1'b0;
            if (w_fwd) begin
                r_f_tvalid <= 1'b1;
                r_f_tlast  <= w_last_col;
                r_f_tdata  <= s_axis_tdata;
            end

            if (w_abort) begin
                r_state <= ST_IDLE;
                r_f_rst <= 1'b1;
                r_flush <= '0;
                r_lines <= '0;
                r_to    <= '0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (cfg_start) begin
                            r_state   <= ST_FLUSH;
                            r_err_sof <= 1'b0;
                            r_err_to  <= 1'b0;
                            r_flush   <= FLUSH_LAST;
                        end
                    end
                    ST_FLUSH: begin
                        if (r_flush == '0) begin
                            r_state <= ST_WAIT_SOF;
                            r_f_rst <= 1'b0;
                        end else begin
                            r_flush <= r_flush - 1'b1;
                        end
                    end
                    ST_WAIT_SOF: begin
                        if (w_fwd) begin
                            r_state <= w_eof ? ST_DRAIN : ST_STREAM;
                            r_lines <= '0;
                            r_to    <= '0;
                        end
                    end
                    ST_STREAM: begin
                        // A misplaced SOF drops the beat and retries the frame from a fresh flush.
                        if (w_bad_sof) begin
                            r_state   <= ST_FLUSH;
                            r_f_rst   <= 1'b1;
                            r_err_sof <= 1'b1;
                            r_flush   <= FLUSH_LAST;
                        end else if (w_fwd && w_eof) begin
                            r_state <= ST_DRAIN;
                            r_lines <= '0;
                            r_to    <= '0;
                        end
                    end
                    ST_DRAIN: begin
                        if (w_out_last) begin
                            r_lines <= w_lines_nxt;
                            r_to    <= '0;
                            if (w_lines_nxt == LINES_MAX) begin
                                r_done      <= 1'b1;
                                r_frame_cnt <= r_frame_cnt + 16'd1;
                                r_f_rst     <= 1'b1;
                                r_flush     <= FLUSH_LAST;
                                r_state     <= cfg_continuous ? ST_FLUSH : ST_IDLE;
                            end
                        end else if (r_to == TO_LAST) begin
                            r_err_to <= 1'b1;
                            r_f_rst  <= 1'b1;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_to <= r_to + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_f_rst <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign s_axis_tready = 1'b1;
    assign f_rst_o       = r_f_rst;
    assign f_axis_tdata  = r_f_tdata;
    assign f_axis_tvalid = r_f_tvalid;
    assign f_axis_tlast  = r_f_tlast;
    assign busy_o        = (r_state != ST_IDLE);
    assign frame_done_o  = r_done;
    assign err_sof_o     = r_err_sof;
    assign err_timeout_o = r_err_to;
    assign frame_cnt_o   = r_frame_cnt;

endmodule

// File: tb/tb_gauss_frame_ctrl.sv
// Directed bench for gauss_frame_ctrl on an 8x4 frame: a table of frame scenarios plus
// hand-written abort, continuous-mode and asynchronous-reset sequences.
module tb_gauss_frame_ctrl;

    localparam int W  = 8;
    localparam int H  = 4;
    localparam int NB = W * H;
    localparam int CUT_NONE  = 0;
    localparam int CUT_ERR   = 1;
    localparam int CUT_ABORT = 2;
    localparam int CUT_STOP  = 3;

    logic        clk = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cfg_start = 1'b0;
    logic        cfg_continuous = 1'b0;
    logic        cfg_abort = 1'b0;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic        s_axis_tready;
    logic        f_rst_o;
    logic [7:0]  f_axis_tdata;
    logic        f_axis_tvalid;
    logic        f_axis_tlast;
    logic        f_out_tvalid = 1'b0;
    logic        f_out_tlast = 1'b0;
    logic        busy_o;
    logic        frame_done_o;
    logic        err_sof_o;
    logic        err_timeout_o;
    logic [15:0] frame_cnt_o;

    int   total = 0;
    int   bad = 0;
    int   n_done = 0;
    logic exp_v = 1'b0;
    logic [7:0] exp_d = '0;
    logic exp_l = 1'b0;
    logic c_start = 1'b0;
    logic c_abort = 1'b0;
    logic t_v = 1'b0;
    logic t_l = 1'b0;
    logic mon = 1'b0;
    logic busy_drop = 1'b0;

    typedef struct {
        int         garbage;
        int         err_at;
        int         tlasts;
        logic [7:0] seed;
        logic       exp_sof;
        logic       exp_to;
        int         exp_cnt;
    } vec_t;

    vec_t tbl[4];

    always #5 clk = ~clk;

    gauss_frame_ctrl #(
        .WIDTH         (W),
        .HEIGHT        (H),
        .DATA_WIDTH    (8),
        .OUT_LINES     (2),
        .FLUSH_CYCLES  (4),
        .DRAIN_TIMEOUT (16)
    ) dut (
        .clk            (clk),
        .rst_ni         (rst_ni),
        .cfg_start      (cfg_start),
        .cfg_continuous (cfg_continuous),
        .cfg_abort      (cfg_abort),
        .s_axis_tdata   (s_axis_tdata),
        .s_axis_tvalid  (s_axis_tvalid),
        .s_axis_tuser   (s_axis_tuser),
        .s_axis_tready  (s_axis_tready),
        .f_rst_o        (f_rst_o),
        .f_axis_tdata   (f_axis_tdata),
        .f_axis_tvalid  (f_axis_tvalid),
        .f_axis_tlast   (f_axis_tlast),
        .f_out_tvalid   (f_out_tvalid),
        .f_out_tlast    (f_out_tlast),
        .busy_o         (busy_o),
        .frame_done_o   (frame_done_o),
        .err_sof_o      (err_sof_o),
        .err_timeout_o  (err_timeout_o),
        .frame_cnt_o    (frame_cnt_o)
    );

    always @(negedge clk) begin
        if (frame_done_o) n_done <= n_done + 1;
        if (mon && !busy_o) busy_drop <= 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One cycle: check the beat expected from the previous cycle, then drive the next inputs.
    task automatic tick(input logic v, input logic u, input logic [7:0] d, input logic fwd, input logic lst);
        @(negedge clk);
        chk("f_tvalid", f_axis_tvalid, exp_v);
        if (exp_v) begin
            chk("f_tdata", f_axis_tdata, exp_d);
            chk("f_tlast", f_axis_tlast, exp_l);
        end
        s_axis_tvalid = v;
        s_axis_tuser  = u;
        s_axis_tdata  = d;
        cfg_start     = c_start;
        cfg_abort     = c_abort;
        f_out_tvalid  = t_v;
        f_out_tlast   = t_l;
        c_start = 1'b0;
        c_abort = 1'b0;
        t_v     = 1'b0;
        t_l     = 1'b0;
        exp_v   = fwd;
        exp_d   = d;
        exp_l   = lst;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tuser = 1'b0;
        cfg_start = 1'b0;
        cfg_abort = 1'b0;
        f_out_tvalid = 1'b0;
        f_out_tlast = 1'b0;
        exp_v = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_f_rst", f_rst_o, 1);
        chk("rst_tvalid", f_axis_tvalid, 0);
        chk("rst_tlast", f_axis_tlast, 0);
        chk("rst_tdata", f_axis_tdata, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", frame_done_o, 0);
        chk("rst_err_sof", err_sof_o, 0);
        chk("rst_err_to", err_timeout_o, 0);
        chk("rst_cnt", frame_cnt_o, 0);
        chk("tready", s_axis_tready, 1);
        rst_ni = 1'b1;
        idle(3);
    endtask

    // Counts sampled cycles with f_rst_o high, starting with the next sample.
    task automatic flush_chk(input int exp_n);
        int n;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            idle(1);
            if (!f_rst_o) break;
            n++;
        end
        chk("flush_len", n, exp_n);
        chk("busy_flush", busy_o, 1);
    endtask

    task automatic send(input int garbage, input int cut_at, input int cut_kind, input logic [7:0] seed);
        logic [7:0] d;
        for (int g = 0; g < garbage; g++) tick(1'b1, 1'b0, 8'hE0 + 8'(g), 1'b0, 1'b0);
        for (int b = 0; b < NB; b++) begin
            d = seed + 8'(b * 3);
            if (b == cut_at) begin
                if (cut_kind == CUT_ERR) begin
                    tick(1'b1, 1'b1, d, 1'b0, 1'b0);
                end else if (cut_kind == CUT_ABORT) begin
                    c_abort = 1'b1;
                    tick(1'b1, 1'b0, d, 1'b0, 1'b0);
                end
                return;
            end
            if (b % 5 == 3) idle(1);
            tick(1'b1, b == 0, d, 1'b1, (b % W) == W - 1);
        end
    endtask

    task automatic drain(input logic cont, input int exp_cnt);
        idle(1);
        chk("busy_drain", busy_o, 1);
        t_v = 1'b1; t_l = 1'b1; idle(1);
        idle(2);
        chk("done_early", frame_done_o, 0);
        t_v = 1'b1; idle(1);
        t_v = 1'b1; t_l = 1'b1; idle(1);
        idle(1);
        chk("done_pulse", frame_done_o, 1);
        chk("frame_cnt", frame_cnt_o, exp_cnt);
        chk("busy_after", busy_o, cont);
        chk("f_rst_after", f_rst_o, 1);
    endtask

    task automatic timeout_chk();
        int n;
        n = 0;
        idle(1);
        for (int i = 0; i < 40; i++) begin
            if (err_timeout_o) break;
            n++;
            idle(1);
        end
        chk("drain_cycles", n, 16);
        chk("busy_timeout", busy_o, 0);
        chk("f_rst_timeout", f_rst_o, 1);
        chk("cnt_timeout", frame_cnt_o, 0);
    endtask

    initial begin
        int base;
        tbl[0] = '{0, -1, 2, 8'h10, 1'b0, 1'b0, 1};
        tbl[1] = '{5, -1, 2, 8'h40, 1'b0, 1'b0, 1};
        tbl[2] = '{0, 10, 2, 8'h70, 1'b1, 1'b0, 1};
        tbl[3] = '{0, -1, 0, 8'hA0, 1'b0, 1'b1, 0};

        for (int i = 0; i < 4; i++) begin
            do_reset();
            base = n_done;
            c_start = 1'b1;
            idle(1);
            flush_chk(4);
            if (tbl[i].err_at >= 0) begin
                send(tbl[i].garbage, tbl[i].err_at, CUT_ERR, tbl[i].seed);
                flush_chk(4);
                send(0, -1, CUT_NONE, tbl[i].seed + 8'h05);
            end else begin
                send(tbl[i].garbage, -1, CUT_NONE, tbl[i].seed);
            end
            chk("err_sof", err_sof_o, tbl[i].exp_sof);
            if (tbl[i].tlasts > 0) drain(1'b0, tbl[i].exp_cnt);
            else timeout_chk();
            chk("err_to", err_timeout_o, tbl[i].exp_to);
            idle(2);
            chk("n_done", n_done - base, tbl[i].exp_cnt);
        end

        // Sticky timeout is cleared by the next start; abort mid-stream, then a clean frame.
        base = n_done;
        c_start = 1'b1;
        idle(1);
        flush_chk(4);
        chk("err_to_clr", err_timeout_o, 0);
        send(0, 12, CUT_ABORT, 8'h21);
        idle(1);
        chk("abort_busy", busy_o, 0);
        chk("abort_f_rst", f_rst_o, 1);
        c_start = 1'b1;
        idle(1);
        flush_chk(4);
        send(0, -1, CUT_NONE, 8'h33);
        drain(1'b0, 1);
        idle(2);
        chk("abort_n_done", n_done - base, 1);

        // Continuous mode: three frames back to back.
        do_reset();
        cfg_continuous = 1'b1;
        c_start = 1'b1;
        idle(1);
        flush_chk(4);
        mon = 1'b1;
        for (int f = 0; f < 3; f++) begin
            send(0, -1, CUT_NONE, 8'h50 + 8'(f * 16));
            drain(1'b1, f + 1);
            flush_chk(3);
        end
        mon = 1'b0;
        cfg_continuous = 1'b0;
        c_abort = 1'b1;
        idle(1);
        idle(1);
        chk("cont_stop_busy", busy_o, 0);
        chk("cont_cnt", frame_cnt_o, 3);
        chk("cont_busy_held", busy_drop, 0);

        // Asynchronous reset in the middle of a frame.
        c_start = 1'b1;
        idle(1);
        flush_chk(4);
        send(0, 12, CUT_STOP, 8'h90);
        @(posedge clk);
        #2;
        chk("pre_rst_valid", f_axis_tvalid, 1);
        chk("pre_rst_data", f_axis_tdata, exp_d);
        rst_ni = 1'b0;
        #1;
        chk("arst_f_rst", f_rst_o, 1);
        chk("arst_tvalid", f_axis_tvalid, 0);
        chk("arst_tdata", f_axis_tdata, 0);
        chk("arst_busy", busy_o, 0);
        chk("arst_cnt", frame_cnt_o, 0);
        exp_v = 1'b0;
        s_axis_tvalid = 1'b0;
        s_axis_tuser = 1'b0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        idle(3);
        chk("post_rst_busy", busy_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/gauss_frame_ctrl.md
Name: gauss_frame_ctrl

Overview:
Frame sequencer placed directly upstream of the gauss_filter_1x5 instance. It arms frames on command and holds the filter in synchronous reset between frames. It aligns the incoming pixel stream to start-of-frame, regenerates tlast every WIDTH pixels, and counts filter output lines to detect frame completion. It also reports framing errors, drain timeouts and the number of completed frames.

Parameters:
WIDTH, 640, pixels per line
HEIGHT, 512, lines per frame
DATA_WIDTH, 8, pixel width
OUT_LINES, 510, filter output lines (tlast beats) that mark frame completion
FLUSH_CYCLES, 4, cycles f_rst_o is held high before a frame
DRAIN_TIMEOUT, 4096, max cycles in DRAIN without a filter output tlast

Ports:
clk  in  1  system clock
rst_ni  in  1  asynchronous active-low reset
cfg_start  in  1  one-cycle pulse: arm one frame
cfg_continuous  in  1  1 = re-arm automatically after each frame
cfg_abort  in  1  one-cycle pulse: abandon current frame
s_axis_tdata  in  DATA_WIDTH  source pixel
s_axis_tvalid  in  1  source valid
s_axis_tuser  in  1  start-of-frame marker on first pixel
s_axis_tready  out  1  constant 1
f_rst_o  out  1  active-high synchronous reset to filter
f_axis_tdata  out  DATA_WIDTH  pixel to filter
f_axis_tvalid  out  1  pixel valid to filter
f_axis_tlast  out  1  end of line to filter
f_out_tvalid  in  1  filter m_axis_tvalid (tap)
f_out_tlast  in  1  filter m_axis_tlast (tap)
busy_o  out  1  high in any state except IDLE
frame_done_o  out  1  one-cycle pulse on frame completion
err_sof_o  out  1  sticky: SOF missing/misplaced; cleared by cfg_start
err_timeout_o  out  1  sticky: drain timeout; cleared by cfg_start
frame_cnt_o  out  16  completed frames, wraps at 65535->0

Behaviour:
- Reset (async assert, sync deassert inside block): state IDLE; f_rst_o=1; f_axis_tvalid/tlast/tdata=0; frame_done_o=0; err flags=0; frame_cnt_o=0; busy_o=0; col/row counters 0.
- s_axis_tready is always 1. Beats accepted outside STREAM are discarded.
- State IDLE: f_rst_o=1. On cfg_start go to FLUSH; clear err flags and load flush counter.
- State FLUSH: f_rst_o=1 for exactly FLUSH_CYCLES cycles, then go to WAIT_SOF with f_rst_o=0.
- State WAIT_SOF: discard beats until tvalid&&tuser. That beat is forwarded as col 0/row 0 and the block enters STREAM in the same cycle.
- State STREAM: every tvalid beat is registered to f_axis_* with 1-cycle latency. f_axis_tlast=1 when col==WIDTH-1. col wraps to 0 and row increments. The beat at row HEIGHT-1/col WIDTH-1 moves the block to DRAIN.
- STREAM error: tuser=1 on any beat other than col0/row0 sets err_sof_o; the beat is dropped and the block goes to FLUSH. In FLUSH the pending frame is re-armed, so it retries automatically.
- State DRAIN: count f_out_tvalid&&f_out_tlast. At count OUT_LINES, pulse frame_done_o and increment frame_cnt_o. Then go to FLUSH if cfg_continuous, else IDLE.
- DRAIN timeout: the timeout counter restarts on each output tlast. Reaching DRAIN_TIMEOUT sets err_timeout_o and forces IDLE with no frame_done_o pulse.
- cfg_abort in any non-IDLE state: go to IDLE next cycle; f_axis_tvalid=0 next cycle; counters cleared; no done pulse.
- cfg_start outside IDLE: ignored. cfg_start and cfg_abort together: abort wins.
- f_axis_tvalid is 0 outside STREAM, except for the final registered beat emitted the cycle after entering DRAIN.
- Counter widths are $clog2 of their limits. The output line counter saturates at OUT_LINES.

Decomposition:
- Package gauss_pkg: state enum (IDLE, FLUSH, WAIT_SOF, STREAM, DRAIN), default WIDTH/HEIGHT/DATA_WIDTH, and the COEFF constants shared with the filter.
- One sub-module: gauss_line_counter (col/row counters with wrap, tlast and end-of-frame flags), reused by the filter rework.

Test Plan:
(Parameters for all tests: WIDTH=8, HEIGHT=4, OUT_LINES=2, FLUSH_CYCLES=4.)
1. Nominal frame: cfg_start, then 32 beats with tuser on beat 0; tap supplies 2 tlasts. Expect f_rst_o high 4 cycles; f_axis_tlast on beats 7/15/23/31 at 1-cycle latency; frame_done_o pulse; frame_cnt_o=1; return to IDLE.
2. Pre-SOF garbage: 5 beats without tuser, then a valid frame. Expect the 5 beats not forwarded and the first forwarded beat equal to the tuser beat.
3. Early SOF: tuser reasserted at beat 10. Expect err_sof_o=1, f_rst_o reasserted 4 cycles, next tuser frame completes with frame_cnt_o=1.
4. Continuous mode: cfg_continuous=1, three back-to-back frames. Expect frame_cnt_o=3, FLUSH between frames, busy_o never drops.
5. Drain timeout: DRAIN_TIMEOUT=16, tap gives no tlast. Expect err_timeout_o=1 after 16 cycles in DRAIN, then IDLE, no done pulse.
6. Abort and reset: cfg_abort mid-STREAM gives IDLE next cycle with tvalid=0. rst_ni low mid-frame clears all outputs immediately (async), without waiting for a clock edge.
